// File: rtl/key_loader.sv
// -----------------------------------------------------------------------------
// key_loader
//   Serially loads an activation key for a logic-locked netlist, optionally
//   verifies it with a CRC-8, and commits it to the key output only once the
//   whole load (and check) has succeeded.
//
//   Optional feature macro: KEY_LOADER_CRC_EN
//     undefined : LOAD -> COMMIT after KEY_W bits, err never set
//     defined   : KEY_W key bits + 8 CRC bits (MSB first), LOAD -> CHECK -> COMMIT
//
//   Parameters
//     KEY_W    key width; key[i] drives locked-netlist key input p(i+1)
//     CRC_POLY CRC-8 generator polynomial (init 0, no reflection, no final xor)
//
//   Ports
//     clk      sole clock, rising edge
//     rst      asynchronous active-high reset
//     start    one-cycle request to begin (or restart) a key load
//     sdi      serial key data, key LSB first
//     sdi_vld  sdi holds a valid bit this cycle
//     sdi_rdy  loader accepts a bit this cycle
//     key      committed key
//     key_ok   key holds a committed, checked value
//     busy     load in progress (state other than IDLE)
//     err      last load failed its check (sticky until next start)
// -----------------------------------------------------------------------------
module key_loader #(
   parameter int unsigned KEY_W    = 40,
   parameter logic [7:0]  CRC_POLY = 8'h07
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sdi,
   input  logic             sdi_vld,
   output logic             sdi_rdy,
   output logic [KEY_W-1:0] key,
   output logic             key_ok,
   output logic             busy,
   output logic             err
);

   localparam int unsigned CNT_W = $clog2(KEY_W + 8) + 1;
`ifdef KEY_LOADER_CRC_EN
   localparam int unsigned TOTAL = KEY_W + 8;
`else
   localparam int unsigned TOTAL = KEY_W;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
`ifdef KEY_LOADER_CRC_EN
      , CHECK = 2'd3
`endif
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [KEY_W-1:0]   shadow;
   logic               armed;   // low for the first edge after reset release
`ifdef KEY_LOADER_CRC_EN
   logic [7:0]         crc;
   logic [7:0]         rx_crc;
`endif

   // One serial CRC-8 step, MSB-first shift
   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
      return {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         armed   <= 1'b0;
         cnt     <= '0;
         shadow  <= '0;
         key     <= '0;
         key_ok  <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         sdi_rdy <= 1'b0;
`ifdef KEY_LOADER_CRC_EN
         crc     <= '0;
         rx_crc  <= '0;
`endif
      end else begin
         armed <= 1'b1;
         if (start && armed) begin
            // start from any state (re)begins a load; key/key_ok untouched
            state   <= LOAD;
            busy    <= 1'b1;
            sdi_rdy <= 1'b1;
            cnt     <= '0;
            shadow  <= '0;
            err     <= 1'b0;
`ifdef KEY_LOADER_CRC_EN
            crc     <= '0;
            rx_crc  <= '0;
`endif
         end else begin
            case (state)
               IDLE: begin
                  busy    <= 1'b0;
                  sdi_rdy <= 1'b0;
               end
               LOAD: begin
                  if (sdi_rdy) begin
                     if (sdi_vld) begin
                        for (int unsigned i = 0; i < KEY_W; i++) begin
                           if (cnt == CNT_W'(i)) shadow[i] <= sdi;
                        end
`ifdef KEY_LOADER_CRC_EN
                        if (cnt < CNT_W'(KEY_W)) crc <= crc8_step(crc, sdi);
                        else                     rx_crc <= {rx_crc[6:0], sdi};
`endif
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(TOTAL - 1)) sdi_rdy <= 1'b0;
                     end
                  end else begin
                     // final bit was taken on the previous edge; sdi_rdy already
                     // low, so this extra LOAD cycle sets the commit latency
`ifdef KEY_LOADER_CRC_EN
                     state <= CHECK;
`else
                     state <= COMMIT;
`endif
                  end
               end
`ifdef KEY_LOADER_CRC_EN
               CHECK: begin
                  if (crc == rx_crc) begin
                     state <= COMMIT;
                  end else begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
`endif
               COMMIT: begin
                  key    <= shadow;
                  key_ok <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: begin
                  busy    <= 1'b0;
                  sdi_rdy <= 1'b0;
                  state   <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
